conv3x3_sa: RTL and testbench

Weight-stationary 3×3 systolic convolution array that consumes the skewed three-row column stream from the image input stage. It produces one full-precision valid-mode convolution result per output pixel: (SIZE-2)×(SIZE-2) results per image, in raster order. It sits between the image input stage and the downstream activation/pooling stage.

---
 rtl/conv3x3_sa_pkg.sv | 30 +++
 rtl/conv3x3_sa_pe_row.sv | 38 +++
 rtl/conv3x3_sa.sv | 133 +++++++++++++
 tb/tb_conv3x3_sa.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_sa_pkg.sv
// Shared types, sizes and arithmetic helpers for the 3x3 weight-stationary
// systolic convolution array.
package conv3x3_sa_pkg;

    localparam int SIZE  = 7;
    localparam int DW    = 16;
    localparam int ACC_W = 36;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] col;
        logic [7:0] band;
    } tag_t;

    // Full-precision signed product, already sign-extended to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_prod(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        return ACC_W'(a) * ACC_W'(b);
    endfunction

endpackage

// File: rtl/conv3x3_sa_pe_row.sv
// One PE row: 3-tap FIR over its own input stream plus the partial sum handed
// down from the row above; the result is registered.
module conv_pe_row
    import conv3x3_sa_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [DW-1:0]    w0,
    input  logic signed [DW-1:0]    w1,
    input  logic signed [DW-1:0]    w2,
    input  logic signed [DW-1:0]    x,
    input  logic signed [ACC_W-1:0] psum_in,
    output logic signed [ACC_W-1:0] psum_out
);

    logic signed [DW-1:0]    d1_r;
    logic signed [DW-1:0]    d2_r;
    logic signed [ACC_W-1:0] fir_s;

    // Oldest sample meets w0, newest meets w2.
    always_comb begin
        fir_s = sext_prod(w0, d2_r) + sext_prod(w1, d1_r) + sext_prod(w2, x);
    end

    // Delay line and registered partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r     <= {DW{1'b0}};
            d2_r     <= {DW{1'b0}};
            psum_out <= {ACC_W{1'b0}};
        end else begin
            d1_r     <= x;
            d2_r     <= d1_r;
            psum_out <= psum_in + fir_s;
        end
    end

endmodule

// File: rtl/conv3x3_sa.sv
// Weight-stationary 3x3 systolic convolution: weight file, stream control FSM,
// (col, band) tag pipeline and three chained PE rows.
module conv3x3_sa
    import conv3x3_sa_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_valid,
    input  logic signed [DW-1:0]    w_in,
    input  logic                    srt_sig,
    input  logic signed [DW-1:0]    in1,
    input  logic signed [DW-1:0]    in2,
    input  logic signed [DW-1:0]    in3,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic [7:0]              out_row,
    output logic [7:0]              out_col,
    output logic                    done
);

    state_t               state_r;
    logic signed [DW-1:0] w_r [9];
    logic [3:0]           w_idx_r;
    logic [7:0]           col_r;
    logic [7:0]           band_r;
    tag_t                 tag0_r;
    tag_t                 tag1_r;
    logic                 srt_d_r;
    logic signed [ACC_W-1:0] psum0_s;
    logic signed [ACC_W-1:0] psum1_s;

    // Control FSM, weight loading, sample counters and tag/result pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            for (int i = 0; i < 9; i++) w_r[i] <= {DW{1'b0}};
            w_idx_r   <= 4'd0;
            col_r     <= 8'd0;
            band_r    <= 8'd0;
            tag0_r    <= '0;
            tag1_r    <= '0;
            srt_d_r   <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= 8'd0;
            out_col   <= 8'd0;
            done      <= 1'b0;
        end else begin
            srt_d_r      <= srt_sig;
            tag1_r       <= tag0_r;
            tag0_r.valid <= 1'b0;
            done         <= 1'b0;
            // Columns 0 and 1 of a band only prime the delay lines.
            out_valid    <= tag1_r.valid && (tag1_r.col >= 8'd2);
            if (tag1_r.valid && (tag1_r.col >= 8'd2)) begin
                out_row <= tag1_r.band;
                out_col <= tag1_r.col - 8'd2;
            end else begin
                out_row <= out_row;
                out_col <= out_col;
            end
            case (state_r)
                IDLE: begin
                    if (w_valid) begin
                        w_r[w_idx_r] <= w_in;
                        w_idx_r      <= (w_idx_r == 4'd8) ? 4'd0 : w_idx_r + 4'd1;
                    end else begin
                        w_idx_r <= w_idx_r;
                    end
                    // A new image needs a fresh rising edge of srt_sig.
                    if (srt_sig && !srt_d_r) begin
                        state_r <= STREAM;
                        tag0_r  <= {1'b1, 8'd0, 8'd0};
                        col_r   <= 8'd1;
                        band_r  <= 8'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STREAM: begin
                    if (!srt_sig) begin
                        state_r      <= IDLE;
                        tag0_r.valid <= 1'b0;
                        tag1_r.valid <= 1'b0;
                        out_valid    <= 1'b0;
                    end else begin
                        tag0_r <= {1'b1, col_r, band_r};
                        if (col_r == 8'(SIZE - 1)) begin
                            col_r  <= 8'd0;
                            band_r <= band_r + 8'd1;
                            state_r <= (band_r == 8'(SIZE - 3)) ? DRAIN : STREAM;
                        end else begin
                            col_r   <= col_r + 8'd1;
                            state_r <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (!tag0_r.valid && !tag1_r.valid) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    conv_pe_row u_row0 (
        .clk(clk), .rst_n(rst_n),
        .w0(w_r[0]), .w1(w_r[1]), .w2(w_r[2]), .x(in1),
        .psum_in({ACC_W{1'b0}}), .psum_out(psum0_s)
    );

    conv_pe_row u_row1 (
        .clk(clk), .rst_n(rst_n),
        .w0(w_r[3]), .w1(w_r[4]), .w2(w_r[5]), .x(in2),
        .psum_in(psum0_s), .psum_out(psum1_s)
    );

    conv_pe_row u_row2 (
        .clk(clk), .rst_n(rst_n),
        .w0(w_r[6]), .w1(w_r[7]), .w2(w_r[8]), .x(in3),
        .psum_in(psum1_s), .psum_out(out_data)
    );

endmodule

// File: tb/tb_conv3x3_sa.sv
// Directed, table-driven bench for conv3x3_sa with a direct-convolution reference.
module tb_conv3x3_sa;

    logic               clk;
    logic               rst_n;
    logic               w_valid;
    logic signed [15:0] w_in;
    logic               srt_sig;
    logic signed [15:0] in1;
    logic signed [15:0] in2;
    logic signed [15:0] in3;
    logic               out_valid;
    logic signed [35:0] out_data;
    logic [7:0]         out_row;
    logic [7:0]         out_col;
    logic               done;

    int checks = 0;
    int errors = 0;
    int wm [9];
    int widx;

    typedef struct {
        int     wset;       // -1 none, 0 ones, 1 centre only, 2 minus ones, 3 ten-word wrap
        bit     w_on_start; // last weight word strobed on the stream-start edge
        int     im;         // 0 all ones, 1 7r+c, 2 all 32767
        int     abort_at;   // edge index at which srt_sig is dropped, -1 none
        bit     junk_w;     // w_valid strobes during STREAM
        int     reset_at;   // edge index after which rst_n is pulsed, -1 none
        int     exp_count;
        longint exp_first;
        longint exp_last;
    } vec_t;

    vec_t vecs [9];

    conv3x3_sa dut (
        .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_in(w_in),
        .srt_sig(srt_sig), .in1(in1), .in2(in2), .in3(in3),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int img(input int im, input int r, input int c);
        if (im == 0) return 1;
        if (im == 1) return 7 * r + c;
        return 32767;
    endfunction

    function automatic int wword(input int ws, input int i);
        case (ws)
            0:       return 1;
            1:       return (i == 4) ? 1 : 0;
            2:       return -1;
            3:       return (i == 4) ? 1 : ((i == 9) ? 2 : 0);
            default: return 0;
        endcase
    endfunction

    task automatic model_load(input int val);
        wm[widx] = val;
        widx = (widx == 8) ? 0 : widx + 1;
    endtask

    function automatic longint conv_ref(input int im, input int r, input int c);
        longint s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += longint'(wm[i*3+j]) * longint'(img(im, r + i, c + j));
        return s;
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_data"}, out_data, 0);
        chk({tag, " out_row"}, out_row, 0);
        chk({tag, " out_col"}, out_col, 0);
        chk({tag, " done"}, done, 0);
    endtask

    task automatic run_vec(input int vi);
        vec_t   v;
        int     nw, nload, cnt, n;
        bit     ev, seen;
        longint first_d, last_d, got_d;
        v = vecs[vi];
        nw = (v.wset < 0) ? 0 : ((v.wset == 3) ? 10 : 9);
        nload = v.w_on_start ? nw - 1 : nw;
        srt_sig = 1'b0; in1 = 16'sd0; in2 = 16'sd0; in3 = 16'sd0;
        for (int i = 0; i < nload; i++) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_in = 16'(wword(v.wset, i));
            model_load(wword(v.wset, i));
        end
        @(negedge clk);
        w_valid = 1'b0; w_in = 16'sd0;
        @(negedge clk);
        cnt = 0; seen = 1'b0; first_d = 0; last_d = 0;
        for (int k = 0; k < 46; k++) begin
            srt_sig = (k <= 40) && (v.abort_at < 0 || k < v.abort_at);
            in1 = (k <= 34) ? 16'(img(v.im, k / 7, k % 7)) : 16'sd0;
            in2 = (k >= 1 && k <= 35) ? 16'(img(v.im, (k - 1) / 7 + 1, (k - 1) % 7)) : 16'sd0;
            in3 = (k >= 2 && k <= 36) ? 16'(img(v.im, (k - 2) / 7 + 2, (k - 2) % 7)) : 16'sd0;
            w_valid = 1'b0; w_in = 16'sd0;
            if (k == 0 && v.w_on_start) begin
                w_valid = 1'b1;
                w_in = 16'(wword(v.wset, nw - 1));
                model_load(wword(v.wset, nw - 1));
            end else if (v.junk_w && k >= 3 && k < 9) begin
                w_valid = 1'b1;
                w_in = 16'sd100;
            end
            @(negedge clk);
            if (!(v.abort_at >= 0 && k == v.abort_at)) begin
                n = k - 2;
                ev = (n >= 0) && (n <= 34) && (n % 7 >= 2) && (v.abort_at < 0 || n < v.abort_at - 2);
                chk($sformatf("v%0d valid k%0d", vi, k), out_valid, ev);
                if (out_valid && ev) begin
                    got_d = out_data;
                    chk($sformatf("v%0d data k%0d", vi, k), got_d, conv_ref(v.im, n / 7, n % 7 - 2));
                    chk($sformatf("v%0d row k%0d", vi, k), out_row, n / 7);
                    chk($sformatf("v%0d col k%0d", vi, k), out_col, n % 7 - 2);
                    if (!seen) first_d = got_d;
                    seen = 1'b1;
                    last_d = got_d;
                end
                if (out_valid) cnt++;
                chk($sformatf("v%0d done k%0d", vi, k), done, (v.abort_at < 0 && v.reset_at < 0 && k == 37));
            end
            if (k == v.reset_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero_outputs($sformatf("v%0d async reset", vi));
                srt_sig = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 9; i++) wm[i] = 0;
                widx = 0;
                break;
            end
        end
        srt_sig = 1'b0; in1 = 16'sd0; in2 = 16'sd0; in3 = 16'sd0;
        w_valid = 1'b0;
        chk($sformatf("v%0d result count", vi), cnt, v.exp_count);
        chk($sformatf("v%0d first result", vi), first_d, v.exp_first);
        chk($sformatf("v%0d last result", vi), last_d, v.exp_last);
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 0, -1, 1'b0, -1, 25, 64'sd9, 64'sd9};
        vecs[1] = '{1, 1'b0, 1, -1, 1'b0, -1, 25, 64'sd8, 64'sd40};
        vecs[2] = '{0, 1'b1, 1, -1, 1'b0, -1, 25, 64'sd72, 64'sd360};
        vecs[3] = '{2, 1'b0, 2, -1, 1'b0, -1, 25, -64'sd294903, -64'sd294903};
        vecs[4] = '{0, 1'b0, 1, 12, 1'b0, -1, 6, 64'sd72, 64'sd135};
        vecs[5] = '{-1, 1'b0, 1, -1, 1'b0, -1, 25, 64'sd72, 64'sd360};
        vecs[6] = '{-1, 1'b0, 1, -1, 1'b1, -1, 25, 64'sd72, 64'sd360};
        vecs[7] = '{3, 1'b0, 1, -1, 1'b0, -1, 25, 64'sd8, 64'sd104};
        vecs[8] = '{-1, 1'b0, 1, -1, 1'b0, 20, 13, 64'sd8, 64'sd56};

        for (int i = 0; i < 9; i++) wm[i] = 0;
        widx = 0;
        rst_n = 1'b0; w_valid = 1'b0; w_in = 16'sd0;
        srt_sig = 1'b0; in1 = 16'sd0; in2 = 16'sd0; in3 = 16'sd0;
        #12 check_zero_outputs("reset state");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int vi = 0; vi < 9; vi++) run_vec(vi);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
